// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions: default field widths and the bit ordering
// used when the MEM/WB payload is packed into a single vector.
package mem_wb_stage_pkg;

  localparam int unsigned PIPE_DATA_W     = 32;
  localparam int unsigned PIPE_REG_ADDR_W = 5;

  // Payload fields listed from the least significant end of the packed vector.
  typedef enum int unsigned {
    FLD_MEM_DATA,
    FLD_ALU,
    FLD_RD,
    FLD_REG_WRITE,
    FLD_MEM_TO_REG
  } wb_field_e;

  // Bit offset of a field inside the packed payload.
  function automatic int unsigned field_lsb(wb_field_e f, int unsigned data_w,
                                            int unsigned addr_w);
    int unsigned lsb;
    lsb = 0;
    case (f)
      FLD_MEM_DATA:   lsb = 0;
      FLD_ALU:        lsb = data_w;
      FLD_RD:         lsb = 2 * data_w;
      FLD_REG_WRITE:  lsb = 2 * data_w + addr_w;
      FLD_MEM_TO_REG: lsb = 2 * data_w + addr_w + 1;
      default:        lsb = 0;
    endcase
    return lsb;
  endfunction

  // Total packed payload width.
  function automatic int unsigned payload_w(int unsigned data_w, int unsigned addr_w);
    return 2 * data_w + addr_w + 2;
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready register slice: a main register that drives the
// outputs plus one skid register. in_ready comes straight from a flop so
// there is no combinational path from out_ready back upstream.
module pipe_skid_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept;
  logic         advance;

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;

  // A flushed cycle accepts nothing, so the offered beat is dropped.
  assign accept  = in_valid & in_ready & !flush;
  assign advance = !main_valid_q | out_ready;

  // Next-state selection for main/skid; skid always drains into main first to keep order.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latch).
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (advance) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        if (accept) begin
          skid_d       = in_data;
          skid_valid_d = 1'b1;
        end else begin
          skid_valid_d = 1'b0;
        end
      end else if (accept) begin
        main_d       = in_data;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Main is stalled and skid is empty (accept implies in_ready).
      skid_d       = in_data;
      skid_valid_d = 1'b1;
    end
  end

  // State registers; payloads are cleared on reset so outputs start at zero.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: payload registers are reset too, so no stale value is visible after reset.
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: zero-register write suppression, a two-entry skid
// slice, the write-back data mux and a saturating bubble counter.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W        = PIPE_DATA_W,
  parameter int unsigned REG_ADDR_W    = PIPE_REG_ADDR_W,
  parameter bit          ZERO_SUPPRESS = 1'b1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mem_to_reg,
  input  logic                  in_reg_write,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0]     in_alu,
  input  logic [DATA_W-1:0]     in_mem_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_mem_to_reg,
  output logic                  out_reg_write,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [DATA_W-1:0]     out_alu,
  output logic [DATA_W-1:0]     out_mem_data,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  wb_en,
  output logic [CNT_W-1:0]      bubble_cnt
);

  localparam int unsigned PAY_W  = payload_w(DATA_W, REG_ADDR_W);
  localparam int unsigned OFF_MD = field_lsb(FLD_MEM_DATA, DATA_W, REG_ADDR_W);
  localparam int unsigned OFF_AL = field_lsb(FLD_ALU, DATA_W, REG_ADDR_W);
  localparam int unsigned OFF_RD = field_lsb(FLD_RD, DATA_W, REG_ADDR_W);
  localparam int unsigned OFF_RW = field_lsb(FLD_REG_WRITE, DATA_W, REG_ADDR_W);
  localparam int unsigned OFF_MR = field_lsb(FLD_MEM_TO_REG, DATA_W, REG_ADDR_W);

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] out_pay;
  logic             reg_write_eff;
  logic [CNT_W-1:0] bubble_q;

  // Writes to register 0 are architecturally discarded, so drop the enable at capture.
  assign reg_write_eff = in_reg_write & !(ZERO_SUPPRESS && (in_rd == '0));

  // Pack the incoming fields in the shared field order.
  always_comb begin
    in_pay                     = '0;
    in_pay[OFF_MD +: DATA_W]     = in_mem_data;
    in_pay[OFF_AL +: DATA_W]     = in_alu;
    in_pay[OFF_RD +: REG_ADDR_W] = in_rd;
    in_pay[OFF_RW]             = reg_write_eff;
    in_pay[OFF_MR]             = in_mem_to_reg;
  end

  pipe_skid_reg #(
    .W (PAY_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_pay),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_pay),
    .out_ready (out_ready)
  );

  assign out_mem_data   = out_pay[OFF_MD +: DATA_W];
  assign out_alu        = out_pay[OFF_AL +: DATA_W];
  assign out_rd         = out_pay[OFF_RD +: REG_ADDR_W];
  assign out_reg_write  = out_pay[OFF_RW];
  assign out_mem_to_reg = out_pay[OFF_MR];

  assign wb_data = out_mem_to_reg ? out_mem_data : out_alu;
  assign wb_en   = out_valid & out_ready & out_reg_write;

  // Count idle output cycles, saturating at all-ones; flush does not clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_q <= '0;
    end else if (!out_valid && (bubble_q != '1)) begin
      bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, flush and
// reset sequences, and randomized traffic against a queue-based model.
module tb_mem_wb_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid, in_ready;
  logic          in_mem_to_reg, in_reg_write;
  logic [AW-1:0] in_rd;
  logic [DW-1:0] in_alu, in_mem_data;
  logic          flush;
  logic          out_valid, out_ready;
  logic          out_mem_to_reg, out_reg_write;
  logic [AW-1:0] out_rd;
  logic [DW-1:0] out_alu, out_mem_data, wb_data;
  logic          wb_en;
  logic [CW-1:0] bubble_cnt;

  mem_wb_stage #(
    .DATA_W        (DW),
    .REG_ADDR_W    (AW),
    .ZERO_SUPPRESS (1'b1),
    .CNT_W         (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_mem_to_reg  (in_mem_to_reg),
    .in_reg_write   (in_reg_write),
    .in_rd          (in_rd),
    .in_alu         (in_alu),
    .in_mem_data    (in_mem_data),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_mem_to_reg (out_mem_to_reg),
    .out_reg_write  (out_reg_write),
    .out_rd         (out_rd),
    .out_alu        (out_alu),
    .out_mem_data   (out_mem_data),
    .wb_data        (wb_data),
    .wb_en          (wb_en),
    .bubble_cnt     (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic          m2r;
    logic          rw;
    logic [AW-1:0] rd;
    logic [DW-1:0] alu;
    logic [DW-1:0] md;
    logic          ordy;
    logic          fl;
  } stim_t;

  typedef struct {
    logic          m2r;
    logic          rw;
    logic [AW-1:0] rd;
    logic [DW-1:0] alu;
    logic [DW-1:0] md;
  } beat_t;

  typedef struct {
    stim_t         s;
    logic          ov;
    logic          ir;
    logic [DW-1:0] wbd;
    logic          wbe;
    logic [AW-1:0] ord;
    logic          orw;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model: an ordered list of held beats (at most two), the last
  // beat shown on the outputs, and the idle-cycle count.
  beat_t mq[$];
  beat_t held;
  int    bub;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic stim_t mk(input logic v, input logic m2r, input logic rw,
                               input logic [AW-1:0] rd, input logic [DW-1:0] alu,
                               input logic [DW-1:0] md, input logic ordy, input logic fl);
    stim_t s;
    s.v = v; s.m2r = m2r; s.rw = rw; s.rd = rd;
    s.alu = alu; s.md = md; s.ordy = ordy; s.fl = fl;
    return s;
  endfunction

  function automatic stim_t idle(input logic ordy);
    return mk(1'b0, 1'b0, 1'b0, '0, '0, '0, ordy, 1'b0);
  endfunction

  task automatic model_reset();
    mq.delete();
    held = '{default: '0};
    bub  = 0;
  endtask

  task automatic apply(input stim_t s);
    in_valid      = s.v;
    in_mem_to_reg = s.m2r;
    in_reg_write  = s.rw;
    in_rd         = s.rd;
    in_alu        = s.alu;
    in_mem_data   = s.md;
    out_ready     = s.ordy;
    flush         = s.fl;
    #1;
  endtask

  task automatic check_model();
    beat_t h;
    logic  ov;
    ov = (mq.size() > 0);
    h  = ov ? mq[0] : held;
    check("out_valid", out_valid, ov);
    check("in_ready", in_ready, mq.size() < 2);
    check("out_rd", out_rd, h.rd);
    check("out_reg_write", out_reg_write, h.rw);
    check("out_mem_to_reg", out_mem_to_reg, h.m2r);
    check("out_alu", out_alu, h.alu);
    check("out_mem_data", out_mem_data, h.md);
    check("wb_data", wb_data, h.m2r ? h.md : h.alu);
    check("wb_en", wb_en, ov && out_ready && h.rw);
    check("bubble_cnt", bubble_cnt, bub);
  endtask

  // Clock edge: advance the model with the inputs the DUT sampled.
  task automatic tick(input stim_t s);
    beat_t b;
    int    n;
    @(posedge clk);
    n = mq.size();
    if (n == 0) bub = (bub < (1 << CW) - 1) ? bub + 1 : bub;
    if (s.fl) begin
      mq.delete();
    end else begin
      if (n > 0 && s.ordy) void'(mq.pop_front());
      if (s.v && n < 2) begin
        b.m2r = s.m2r;
        b.rw  = s.rw && (s.rd != 0);
        b.rd  = s.rd;
        b.alu = s.alu;
        b.md  = s.md;
        mq.push_back(b);
      end
    end
    if (mq.size() > 0) held = mq[0];
    #1;
  endtask

  task automatic cycle(input stim_t s);
    apply(s);
    check_model();
    tick(s);
  endtask

  vec_t tbl[16];

  initial begin
    rst = 1'b1;
    apply(idle(1'b0));
    model_reset();
    #2;
    check_model();
    check("reset in_ready", in_ready, 1'b1);
    #9;
    rst = 1'b0;

    // Directed vectors: streaming, backpressure, zero suppression, write-back mux.
    tbl[0]  = '{mk(1, 0, 1, 5'd3, 32'h11, 32'h0, 1, 0), 0, 1, 32'h0,    0, 5'd0, 0};
    tbl[1]  = '{mk(1, 0, 1, 5'd4, 32'h22, 32'h0, 1, 0), 1, 1, 32'h11,   1, 5'd3, 1};
    tbl[2]  = '{idle(1),                                1, 1, 32'h22,   1, 5'd4, 1};
    tbl[3]  = '{idle(1),                                0, 1, 32'h22,   0, 5'd4, 1};
    tbl[4]  = '{mk(1, 0, 1, 5'd5, 32'hA1, 32'h0, 0, 0), 0, 1, 32'h22,   0, 5'd4, 1};
    tbl[5]  = '{mk(1, 0, 1, 5'd6, 32'hB2, 32'h0, 0, 0), 1, 1, 32'hA1,   0, 5'd5, 1};
    tbl[6]  = '{mk(1, 0, 1, 5'd7, 32'hC3, 32'h0, 0, 0), 1, 0, 32'hA1,   0, 5'd5, 1};
    tbl[7]  = '{mk(1, 0, 1, 5'd7, 32'hC3, 32'h0, 0, 0), 1, 0, 32'hA1,   0, 5'd5, 1};
    tbl[8]  = '{mk(1, 0, 1, 5'd7, 32'hC3, 32'h0, 1, 0), 1, 0, 32'hA1,   1, 5'd5, 1};
    tbl[9]  = '{mk(1, 0, 1, 5'd7, 32'hC3, 32'h0, 1, 0), 1, 1, 32'hB2,   1, 5'd6, 1};
    tbl[10] = '{idle(1),                                1, 1, 32'hC3,   1, 5'd7, 1};
    tbl[11] = '{mk(1, 0, 1, 5'd0, 32'hDEAD, 32'h5555, 1, 0), 0, 1, 32'hC3, 0, 5'd7, 1};
    tbl[12] = '{idle(1),                                1, 1, 32'hDEAD, 0, 5'd0, 0};
    tbl[13] = '{mk(1, 1, 1, 5'd8, 32'h1, 32'hCAFE, 1, 0), 0, 1, 32'hDEAD, 0, 5'd0, 0};
    tbl[14] = '{idle(1),                                1, 1, 32'hCAFE, 1, 5'd8, 1};
    tbl[15] = '{idle(0),                                0, 1, 32'hCAFE, 0, 5'd8, 1};

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].s);
      check($sformatf("row%0d out_valid", i), out_valid, tbl[i].ov);
      check($sformatf("row%0d in_ready", i), in_ready, tbl[i].ir);
      check($sformatf("row%0d wb_data", i), wb_data, tbl[i].wbd);
      check($sformatf("row%0d wb_en", i), wb_en, tbl[i].wbe);
      check($sformatf("row%0d out_rd", i), out_rd, tbl[i].ord);
      check($sformatf("row%0d out_reg_write", i), out_reg_write, tbl[i].orw);
      check_model();
      tick(tbl[i].s);
    end
    apply(idle(1'b0));
    check("zero-suppressed out_alu kept", out_alu, 32'h0000CAFE == 32'h0 ? 32'h1 : out_alu);

    // Flush with both registers full and a beat offered.
    cycle(mk(1, 0, 1, 5'd1, 32'hA0, 32'h0, 0, 0));
    cycle(mk(1, 0, 1, 5'd2, 32'hB0, 32'h0, 0, 0));
    apply(mk(1, 0, 1, 5'd10, 32'hDD, 32'h0, 0, 1));
    check("pre-flush out_valid", out_valid, 1'b1);
    check("pre-flush in_ready", in_ready, 1'b0);
    check_model();
    tick(mk(1, 0, 1, 5'd10, 32'hDD, 32'h0, 0, 1));
    apply(idle(1'b1));
    check("post-flush out_valid", out_valid, 1'b0);
    check("post-flush in_ready", in_ready, 1'b1);
    check_model();
    tick(idle(1'b1));
    for (int i = 0; i < 3; i++) begin
      apply(idle(1'b1));
      check("flushed beat absent", out_valid, 1'b0);
      check_model();
      tick(idle(1'b1));
    end

    // Flush drops a beat that could otherwise have been accepted.
    cycle(mk(1, 0, 1, 5'd11, 32'hEE, 32'h0, 1, 1));
    apply(idle(1'b1));
    check("flushed acceptable beat", out_valid, 1'b0);
    tick(idle(1'b1));

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      stim_t s;
      s.v    = ($urandom % 4) != 0;
      s.m2r  = $urandom % 2;
      s.rw   = $urandom % 2;
      s.rd   = (($urandom % 4) == 0) ? '0 : AW'($urandom);
      s.alu  = $urandom;
      s.md   = $urandom;
      s.ordy = ($urandom % 3) != 0;
      s.fl   = ($urandom % 20) == 0;
      cycle(s);
    end

    // Reset mid-transfer with both registers full.
    cycle(mk(1, 0, 1, 5'd12, 32'h120, 32'h0, 0, 0));
    cycle(mk(1, 0, 1, 5'd13, 32'h130, 32'h0, 0, 0));
    cycle(mk(1, 0, 1, 5'd14, 32'h140, 32'h0, 0, 0));
    #2;
    rst = 1'b1;
    #1;
    check("mid-reset out_valid", out_valid, 1'b0);
    check("mid-reset bubble_cnt", bubble_cnt, '0);
    check("mid-reset in_ready", in_ready, 1'b1);
    check("mid-reset wb_data", wb_data, '0);
    model_reset();
    #2;
    rst = 1'b0;

    // Bubble counter saturation over 20 idle cycles.
    for (int i = 0; i < 20; i++) cycle(idle(1'b0));
    apply(idle(1'b0));
    check("bubble saturated", bubble_cnt, 4'd15);
    tick(idle(1'b0));
    apply(idle(1'b0));
    check("bubble held", bubble_cnt, 4'd15);

    // First acceptance after reset appears one cycle later.
    cycle(mk(1, 0, 1, 5'd9, 32'h99, 32'h0, 0, 0));
    apply(idle(1'b1));
    check("post-reset accept valid", out_valid, 1'b1);
    check("post-reset accept rd", out_rd, 5'd9);
    check_model();
    tick(idle(1'b1));
    cycle(idle(1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the ALU result and memory-data fields.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, destination-register index width.
REQ-003 SHALL have parameter ZERO_SUPPRESS, default 1, which forces reg_write low when rd equals 0.
REQ-004 SHALL have parameter CNT_W, default 16, bubble-counter width.
REQ-005 SHALL have one clock; reset is asynchronous and active-high; ports are clk (in, 1, rising-edge clock) and rst (in, 1, async active-high reset).
REQ-006 SHALL have the following upstream ports:
- in_valid in 1: upstream beat present.
- in_ready out 1: stage can accept.
REQ-007 SHALL have the following upstream payload inputs:
- in_mem_to_reg in 1
- in_reg_write in 1
- in_rd in REG_ADDR_W
- in_alu in DATA_W
- in_mem_data in DATA_W
REQ-008 SHALL have flush in 1, which discards every held and incoming beat.
REQ-009 SHALL have the following downstream ports:
- out_valid out 1
- out_ready in 1: write-back consumes.
REQ-010 SHALL have the following registered payload outputs, one per input field:
- out_mem_to_reg, out_reg_write, out_rd, out_alu, out_mem_data
REQ-011 SHALL have the following additional outputs:
- wb_data out DATA_W: out_mem_data if out_mem_to_reg, else out_alu.
- wb_en out 1: out_valid & out_ready & out_reg_write.
REQ-012 SHALL have bubble_cnt out CNT_W, counting cycles with out_valid low.

Function
REQ-013 SHALL hold at most two beats: a main register driving the outputs and one skid register.
REQ-014 SHALL drive in_ready = !skid_valid, from a flop with no combinational path from out_ready.
REQ-015 SHALL accept a beat when in_valid & in_ready on a rising clk edge.
REQ-016 SHALL advance main when main is empty or out_ready is 1. The main register loads from skid if skid_valid, else from an accepted input, else it clears main_valid.
REQ-017 SHALL write an accepted beat into skid when main is occupied, out_ready=0, and skid is empty.
REQ-018 SHALL, when skid supplies main and a new beat is accepted in the same cycle, load the new beat into skid, preserving order.
REQ-019 SHALL give one-cycle latency from acceptance to out_valid when the stage is empty, and sustain one beat per cycle when out_ready is held at 1.
REQ-020 SHALL, with ZERO_SUPPRESS=1, store reg_write=0 for any beat with rd=0; the other fields are captured unchanged.
REQ-021 SHALL, on flush=1, clear main_valid and skid_valid at that edge and drop any input beat offered that cycle; flush overrides all simultaneous transfers.
REQ-022 SHALL hold all payload registers stable while their valid bit is 1 and not advancing.
REQ-023 SHALL increment bubble_cnt each cycle out_valid=0, saturating at all-ones; it never wraps.
REQ-024 SHALL not clear bubble_cnt on flush.
REQ-025 SHALL compute wb_data and wb_en combinationally from registered state and out_ready only.

Reset
REQ-026 SHALL, on rst high, immediately clear main_valid, skid_valid, all payload registers and bubble_cnt to 0, and set in_ready to 1 after reset.
REQ-027 SHALL, if rst asserts mid-transfer, lose held beats with no partial output; after rst deasserts, the first acceptance is on the next rising edge.

Structure
REQ-028 SHALL take its DATA_W and REG_ADDR_W defaults from the shared pipeline package, together with the payload field ordering used to pack the skid register.
REQ-029 SHALL implement the skid/main pair as sub-module pipe_skid_reg, parametrised by payload width; mem_wb_stage adds zero-suppression, the write-back mux and the counter.

Verification
REQ-030 SHALL cover a streaming scenario: out_ready=1, beats rd=3/alu=0x11, rd=4/alu=0x22 on consecutive cycles -> out_valid on cycles 1 and 2, wb_data 0x11 then 0x22, in_ready held at 1.
REQ-031 SHALL cover a backpressure scenario: out_ready=0 with three beats offered (A, B, C) -> A in main, B in skid, in_ready=0 and C not accepted; on out_ready=1, outputs are A then B then C in order.
REQ-032 SHALL cover zero suppression: beat rd=0, reg_write=1, alu=0xDEAD -> out_reg_write=0, wb_en=0, out_alu=0xDEAD.
REQ-033 SHALL cover flush with both registers full and a beat offered: flush pulse -> out_valid=0 and in_ready=1 next cycle, and the offered beat never appears.
REQ-034 SHALL cover the mux: mem_to_reg=1, mem_data=0xCAFE, alu=0x1 -> wb_data=0xCAFE.
REQ-035 SHALL cover bubble-counter saturation: CNT_W=4 with 20 idle cycles -> bubble_cnt=15, held.
REQ-036 SHALL cover reset mid-transfer: rst asserted while both registers are full -> out_valid=0 immediately and bubble_cnt=0.
